data_sram_resp: RTL and testbench

Responder end of the data SRAM interface: accepts the access that the execute stage issues and returns the read word that the memory stage samples one cycle later as `data_sram_rdata`. It implements a word-addressed, byte-writable synchronous RAM with a one-cycle read latency. After reset it runs a clear sequence that zeroes the array. It flags accesses outside its window and keeps read/write access counters for the bench and for debug.

---
 rtl/data_sram_resp_pkg.sv | 17 +
 rtl/data_sram_resp_if.sv | 12 +
 rtl/data_sram_resp_sram_bytewe_1p.sv | 49 ++++
 rtl/data_sram_resp.sv | 74 +++++++
 tb/tb_data_sram_resp.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared widths, FSM encoding and window helper for the data SRAM responder.
package data_sram_resp_pkg;
  localparam int DATA_SRAM_ADDR_WD = 32;
  localparam int DATA_SRAM_WE_WD   = 4;
  localparam int DATA_SRAM_DATA_WD = 32;
  localparam int NUM_LANES         = DATA_SRAM_WE_WD;
  localparam int VEC_W             = DATA_SRAM_DATA_WD / NUM_LANES;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  // Only bits above the word index and byte offset select the window.
  function automatic logic in_window(input logic [DATA_SRAM_ADDR_WD-1:0] addr,
                                     input logic [DATA_SRAM_ADDR_WD-1:0] base,
                                     input int aw);
    return ((addr ^ base) >> (aw + 2)) == '0;
  endfunction
endpackage

// File: rtl/data_sram_resp_if.sv
// Data SRAM request/response bus between execute/memory stages and the responder.
interface data_sram_if;
  import data_sram_resp_pkg::*;
  logic                         en;
  logic [DATA_SRAM_WE_WD-1:0]   we;
  logic [DATA_SRAM_ADDR_WD-1:0] addr;
  logic [DATA_SRAM_DATA_WD-1:0] wdata;
  logic [DATA_SRAM_DATA_WD-1:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_resp_sram_bytewe_1p.sv
// Single-port byte-writable array, read-first registered read, clear-port mux.
module sram_bytewe_1p
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clr,
  input  logic [ADDR_W-1:0]                clr_idx,
  input  logic                             acc,
  input  logic                             rd_zero,
  input  logic [ADDR_W-1:0]                idx,
  input  logic [NUM_LANES-1:0]             we,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]  wdata,
  output logic [NUM_LANES-1:0][VEC_W-1:0]  rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [NUM_LANES-1:0][VEC_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]               w_idx;
  logic [NUM_LANES-1:0]            w_en;
  logic [NUM_LANES-1:0][VEC_W-1:0] w_data;

  // Clear sequence owns the write port; requests never reach it then.
  always_comb begin
    w_idx  = idx;
    w_en   = acc ? we : '0;
    w_data = wdata;
    if (clr) begin
      w_idx  = clr_idx;
      w_en   = '1;
      w_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++)
      if (w_en[l]) mem[w_idx][l] <= w_data[l];
  end

  // Read samples pre-write contents in the same edge as the write.
  always_ff @(posedge clk) begin
    if (reset)        rdata <= '0;
    else if (acc)     rdata <= mem[idx];
    else if (rd_zero) rdata <= '0;
  end
endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: post-reset clear FSM, window check, access counters.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int                           ADDR_W    = 14,
  parameter logic [DATA_SRAM_ADDR_WD-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  data_sram_if.slave  bus,
  output logic        init_done,
  output logic        err_oob,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);
  state_t                        state, state_nxt;
  logic [ADDR_W-1:0]             ptr;
  logic                          clr, in_win, acc, oob;
  logic [DATA_SRAM_DATA_WD-1:0]  rdata_q;

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (ptr == '1) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    clr       = (state == CLEAR);
    init_done = (state == RUN);
    in_win    = in_window(bus.addr, BASE_ADDR, ADDR_W);
    acc       = (state == RUN) && bus.en && in_win && !reset;
    oob       = (state == RUN) && bus.en && !in_win && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset)    ptr <= '0;
    else if (clr) ptr <= ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_oob <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      if (oob) err_oob <= 1'b1;
      if (acc && bus.we == '0) rd_cnt <= rd_cnt + 32'd1;
      if (acc && bus.we != '0) wr_cnt <= wr_cnt + 32'd1;
    end
  end

  sram_bytewe_1p #(.ADDR_W(ADDR_W)) u_sram (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .clr_idx (ptr),
    .acc     (acc),
    .rd_zero (oob),
    .idx     (bus.addr[ADDR_W+1:2]),
    .we      (bus.we),
    .wdata   (bus.wdata),
    .rdata   (rdata_q)
  );

  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// Randomized self-checking bench for data_sram_resp with a word-array reference model.
module tb_data_sram_resp;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done, err_oob;
  logic [31:0] rd_cnt, wr_cnt;

  data_sram_if bus();

  data_sram_resp #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .init_done(init_done), .err_oob(err_oob), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_rd, m_wr;
  int          m_clr_left = DEPTH;

  // Drive one cycle from a negedge, advance the model at the posedge, return at next negedge.
  task automatic step(input logic rst, input logic en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int w;
    reset = rst; bus.en = en; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    @(posedge clk);
    if (rst) begin
      m_rdata = 0; m_err = 0; m_rd = 0; m_wr = 0; m_clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    end else if (m_clr_left > 0) begin
      m_clr_left--;
    end else if (en) begin
      if ((addr >> (AW + 2)) == (BASE >> (AW + 2))) begin
        w = int'((addr >> 2) % DEPTH);
        m_rdata = m_mem[w];
        for (int b = 0; b < 4; b++)
          if (we[b]) m_mem[w][8*b +: 8] = wdata[8*b +: 8];
        if (we == 4'h0) m_rd++; else m_wr++;
      end else begin
        m_rdata = 0; m_err = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
  endtask

  task automatic test_reset();
    int n;
    step(1'b1, 1'b1, 4'hF, 32'h0, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    checks++; if (err_oob !== 1'b0 || rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_flags: got err=%b rd=%0d wr=%0d want 0/0/0", err_oob, rd_cnt, wr_cnt); end
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin idle(); n++; end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL init_latency: got %0d cycles want %0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 4'h0, 32'(i * 4), $urandom);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL cleared_word%0d: got %h want 0", i, bus.rdata); end
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    step(1'b0, 1'b1, 4'hF, 32'h8, 32'h1122_3344);
    step(1'b0, 1'b1, 4'b0101, 32'h8, 32'hAABB_CCDD);
    checks++; if (bus.rdata !== 32'h1122_3344) begin errors++; $display("FAIL read_first: got %h want 11223344", bus.rdata); end
    step(1'b0, 1'b1, 4'h0, 32'h8, 32'h0);
    checks++; if (bus.rdata !== 32'h11BB_33DD) begin errors++; $display("FAIL byte_merge: got %h want 11bb33dd", bus.rdata); end
    checks++; if (wr_cnt - wr0 !== 32'd2 || rd_cnt - rd0 !== 32'd1) begin
      errors++; $display("FAIL cnt_delta: got wr+%0d rd+%0d want wr+2 rd+1", wr_cnt - wr0, rd_cnt - rd0); end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 4'h0, 32'h8, $urandom);
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++; if (bus.rdata !== 32'h11BB_33DD) begin errors++; $display("FAIL hold%0d: got %h want 11bb33dd", k, bus.rdata); end
    end
  endtask

  task automatic test_oob();
    logic [31:0] rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    step(1'b0, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D);
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL oob_rdata: got %h want 0", bus.rdata); end
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_flag: got %b want 1", err_oob); end
    checks++; if (rd_cnt !== rd0 || wr_cnt !== wr0) begin
      errors++; $display("FAIL oob_cnt: got rd=%0d wr=%0d want rd=%0d wr=%0d", rd_cnt, wr_cnt, rd0, wr0); end
    step(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
    checks++; if (bus.rdata !== m_mem[0] || err_oob !== 1'b1) begin
      errors++; $display("FAIL oob_alias: got %h err=%b want %h err=1", bus.rdata, err_oob, m_mem[0]); end
    step(1'b0, 1'b1, 4'h0, 32'h8, 32'h0);
    checks++; if (bus.rdata !== 32'h11BB_33DD || err_oob !== 1'b1) begin
      errors++; $display("FAIL oob_sticky: got %h err=%b want 11bb33dd err=1", bus.rdata, err_oob); end
  endtask

  task automatic test_clear_ignore();
    int n;
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin
      if (n == 3) step(1'b0, 1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF);
      else        step(1'b0, 1'b1, 4'($urandom), 32'($urandom_range(0, 63)), $urandom);
      n++;
      checks++; if (n < DEPTH && (bus.rdata !== 32'h0 || err_oob !== 1'b0)) begin
        errors++; $display("FAIL clr_ignore_c%0d: got rdata=%h err=%b want 0/0", n, bus.rdata, err_oob); end
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL clr_latency: got %0d want %0d", n, DEPTH); end
    step(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL clr_word0: got %h want 0", bus.rdata); end
    checks++; if (wr_cnt !== 32'h0 || rd_cnt !== 32'd1) begin
      errors++; $display("FAIL clr_cnt: got rd=%0d wr=%0d want rd=1 wr=0", rd_cnt, wr_cnt); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    for (int i = 1; i < 4; i++) step(1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom | 32'h1);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 7; k++) idle();
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin idle(); n++; end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL reclr_latency: got %0d want %0d", n, DEPTH); end
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b1, 4'h0, 32'(i * 4), 32'h0);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reclr_word%0d: got %h want 0", i, bus.rdata); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  we;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_0040;
      else a = {26'h0, 4'($urandom), 2'($urandom)};
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(1'b0, $urandom_range(0, 3) != 0, we, a, $urandom);
      checks++; if (bus.rdata !== m_rdata || err_oob !== m_err || rd_cnt !== m_rd || wr_cnt !== m_wr) begin
        errors++; $display("FAIL rand%0d: got rdata=%h err=%b rd=%0d wr=%0d want %h %b %0d %0d",
                           k, bus.rdata, err_oob, rd_cnt, wr_cnt, m_rdata, m_err, m_rd, m_wr); end
    end
  endtask

  initial begin
    reset = 1'b1; bus.en = 1'b0; bus.we = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_byte_write();
    test_hold();
    test_oob();
    test_clear_ignore();
    test_reset_mid_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
